// File: rtl/ps2_keyboard_seg.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_seg
//
// PS/2 keyboard receiver. Frames are checked for start, stop and odd parity
// and then queued in an 8-entry scan-code FIFO. The oldest queued code is
// presented on `data` and decoded onto two hex seven-segment digits.
//
// Ports
//   clk         system clock, at least 10x the PS/2 clock
//   clrn        synchronous active-low reset
//   ps2_clk     raw PS/2 clock from the device (asynchronous)
//   ps2_data    raw PS/2 data from the device (asynchronous)
//   nextdata_n  active-low pop request, one entry per clock while low
//   data        scan code at the FIFO head (stale while empty)
//   ready       FIFO holds at least one entry
//   overflow    sticky: a valid frame was dropped because the FIFO was full
//   h1          active-low segments for data[3:0], bit0 = a ... bit6 = g
//   h2          active-low segments for data[7:4], same encoding
// ---------------------------------------------------------------------------
module ps2_keyboard_seg (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic [6:0] h1,
   output logic [6:0] h2
);

   localparam int DEPTH = 8;

   // ------------------------------------------------------------------
   // Input synchronisers. Bit 0 is the newest sample, bit 2 the oldest.
   // They reset to 1 because an idle PS/2 bus floats high.
   // ------------------------------------------------------------------
   logic [2:0] ps2_clk_sync_reg;
   logic [2:0] ps2_data_sync_reg;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         ps2_clk_sync_reg  <= 3'b111;
         ps2_data_sync_reg <= 3'b111;
      end else begin
         ps2_clk_sync_reg  <= {ps2_clk_sync_reg[1:0], ps2_clk};
         ps2_data_sync_reg <= {ps2_data_sync_reg[1:0], ps2_data};
      end
   end

   logic ps2_fall;
   logic ps2_bit;

   // Falling edge: the older of the two oldest samples is 1, the newer 0.
   assign ps2_fall = ps2_clk_sync_reg[2] & ~ps2_clk_sync_reg[1];
   assign ps2_bit  = ps2_data_sync_reg[2];

   // ------------------------------------------------------------------
   // Frame assembly. The buffer shifts in from the top, so after ten
   // edges buffer[0] = start, buffer[8:1] = d7..d0, buffer[9] = parity.
   // The stop bit is never stored; it is the live sample on edge 11.
   // ------------------------------------------------------------------
   logic [3:0] bit_cnt_reg;
   logic [9:0] buffer_reg;
   logic       frame_done;
   logic       frame_valid;

   assign frame_done  = ps2_fall && (bit_cnt_reg == 4'd10);
   assign frame_valid = ~buffer_reg[0] & ps2_bit & (^buffer_reg[9:1]);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         bit_cnt_reg <= 4'd0;
         buffer_reg  <= 10'd0;
      end else if (ps2_fall) begin
         if (bit_cnt_reg == 4'd10) begin
            bit_cnt_reg <= 4'd0;
         end else begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            buffer_reg  <= {ps2_bit, buffer_reg[9:1]};
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic [7:0] fifo_mem [DEPTH];
   logic [2:0] wr_ptr_reg;
   logic [2:0] rd_ptr_reg;
   logic [3:0] count_reg;
   logic [3:0] count_next;
   logic       ready_reg;
   logic       overflow_reg;

   logic push_req;
   logic pop;
   logic push;
   logic drop;

   assign push_req = frame_done & frame_valid;
   assign pop      = ~nextdata_n && (count_reg != 4'd0);
   // A same-cycle pop frees the slot the incoming frame needs. When full,
   // the write pointer equals the read pointer, so the new code lands in
   // exactly the slot being vacated.
   assign push     = push_req && ((count_reg != 4'd8) || pop);
   assign drop     = push_req && (count_reg == 4'd8) && !pop;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 4'd1;
         2'b01:   count_next = count_reg - 4'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         wr_ptr_reg   <= 3'd0;
         rd_ptr_reg   <= 3'd0;
         count_reg    <= 4'd0;
         ready_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
         count_reg <= count_next;
         // Registered from count_next so it always agrees with count_reg.
         ready_reg <= (count_next != 4'd0);
         if (drop) overflow_reg <= 1'b1;
      end
   end

   // Storage is cleared on reset, so it is kept in flops rather than RAM.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= 8'h00;
         end
      end else if (push) begin
         fifo_mem[wr_ptr_reg] <= buffer_reg[8:1];
      end
   end

   assign data     = fifo_mem[rd_ptr_reg];
   assign ready    = ready_reg;
   assign overflow = overflow_reg;

   // ------------------------------------------------------------------
   // Seven-segment decode, active-low, pattern listed as g..a.
   // ------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   assign h1 = hex_to_seg(data[3:0]);
   assign h2 = hex_to_seg(data[7:4]);

endmodule

// File: tb/tb_ps2_keyboard_seg.sv
module tb_ps2_keyboard_seg;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic [6:0] h1;
   logic [6:0] h2;

   int n_cmp = 0;
   int n_err = 0;

   ps2_keyboard_seg dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .h1         (h1),
      .h2         (h2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
   endtask

   // Sends the first nbits bits of a frame. parity is odd parity unless
   // bad_par is set. With pop_last, nextdata_n is held low for exactly the
   // clock edge on which the frame's push takes effect (3rd posedge after
   // ps2_clk falls at a negedge).
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop,
                             input int nbits, input bit pop_last);
      logic [10:0] bits;
      bits = {stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         repeat (5) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10 && pop_last) begin
            repeat (2) @(negedge clk);
            nextdata_n = 1'b0;
            @(negedge clk);
            nextdata_n = 1'b1;
            repeat (7) @(negedge clk);
         end else begin
            repeat (10) @(negedge clk);
         end
         ps2_clk = 1'b1;
         repeat (5) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic pop_one();
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_ready", {7'd0, ready}, 8'h00);
      check("rst_ovf", {7'd0, overflow}, 8'h00);
      check("rst_data", data, 8'h00);
      check("rst_h1", {1'b0, h1}, 8'b0100_0000);
      check("rst_h2", {1'b0, h2}, 8'b0100_0000);

      // Valid 0x1C
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      check("v1c_ready", {7'd0, ready}, 8'h01);
      check("v1c_data", data, 8'h1C);
      check("v1c_h1", {1'b0, h1}, 8'b0100_0110);
      check("v1c_h2", {1'b0, h2}, 8'b0111_1001);

      // Bad parity and bad stop on an empty FIFO
      do_reset();
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
      check("badpar_ready", {7'd0, ready}, 8'h00);
      send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
      check("badstop_ready", {7'd0, ready}, 8'h00);
      check("bad_ovf", {7'd0, overflow}, 8'h00);
      send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
      check("f0_ready", {7'd0, ready}, 8'h01);
      check("f0_data", data, 8'hF0);
      check("f0_h1", {1'b0, h1}, 8'b0100_0000);
      check("f0_h2", {1'b0, h2}, 8'b0000_1110);

      // Pop sequence
      do_reset();
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      check("pop_d0", data, 8'h1C);
      pop_one();
      check("pop_d1", data, 8'hF0);
      pop_one();
      check("pop_d2", data, 8'h1C);
      check("pop_rdy2", {7'd0, ready}, 8'h01);
      pop_one();
      check("pop_rdy3", {7'd0, ready}, 8'h00);
      pop_one();
      check("pop_empty_rdy", {7'd0, ready}, 8'h00);
      send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
      check("after_empty", data, 8'h5A);

      // Reset mid-frame, then a clean frame
      send_frame(8'h33, 1'b0, 1'b1, 5, 1'b0);
      do_reset();
      check("midrst_ready", {7'd0, ready}, 8'h00);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      check("midrst_data", data, 8'h1C);

      // Overflow
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         send_frame(8'(k), 1'b0, 1'b1, 11, 1'b0);
      end
      check("ovf_flag", {7'd0, overflow}, 8'h01);
      for (int k = 1; k <= 8; k++) begin
         check("ovf_pop", data, 8'(k));
         pop_one();
      end
      check("ovf_empty", {7'd0, ready}, 8'h00);
      check("ovf_sticky", {7'd0, overflow}, 8'h01);
      do_reset();
      check("ovf_cleared", {7'd0, overflow}, 8'h00);

      // Full FIFO: pop and push on the same edge
      for (int k = 0; k < 8; k++) begin
         send_frame(8'h11 + 8'(k), 1'b0, 1'b1, 11, 1'b0);
      end
      send_frame(8'h19, 1'b0, 1'b1, 11, 1'b1);
      check("sim_ovf", {7'd0, overflow}, 8'h00);
      check("sim_ready", {7'd0, ready}, 8'h01);
      for (int k = 0; k < 8; k++) begin
         check("sim_pop", data, 8'h12 + 8'(k));
         pop_one();
      end
      check("sim_empty", {7'd0, ready}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
